// File: rtl/taxi_pcie_irq_rr_arb.sv
// Round-robin priority encoder for the interrupt generator.
// Searches the request vector starting one past the last granted index,
// wrapping modulo IRQ_N, and reports the first set bit. Purely combinational.
module taxi_pcie_irq_rr_arb #(
  parameter int IRQ_N = 32,
  parameter int IDX_W = (IRQ_N > 1) ? $clog2(IRQ_N) : 1
) (
  input  logic [IRQ_N-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the lowest priority position up to the highest so the last hit
  // written is the one closest to last+1.
  always_comb begin
    int cand;
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      cand = (int'(last) + 1 + i) % IRQ_N;
      if (req[cand]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/taxi_pcie_irq_gen.sv
// MSI-X interrupt request generator.
// Collects per-vector requests into a pending vector, picks one vector at a
// time round-robin and presents its index on an AXI-stream source.
//
// Handshake: a beat transfers on any clk edge where m_axis_irq_tvalid and
// m_axis_irq_tready are both high; once tvalid is raised, tvalid and tdata
// are held unchanged until that transfer happens (only rst can drop them).
module taxi_pcie_irq_gen #(
  parameter int IRQ_N          = 32,
  parameter int HOLDOFF_CYCLES = 0,
  parameter int DATA_W         = (IRQ_N > 1) ? $clog2(IRQ_N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IRQ_N-1:0]  irq_req,
  input  logic              enable,
  output logic [DATA_W-1:0] m_axis_irq_tdata,
  output logic [0:0]        m_axis_irq_tkeep,
  output logic              m_axis_irq_tvalid,
  input  logic              m_axis_irq_tready,
  output logic              m_axis_irq_tlast,
  output logic [0:0]        m_axis_irq_tid,
  output logic [0:0]        m_axis_irq_tdest,
  output logic [0:0]        m_axis_irq_tuser,
  output logic [IRQ_N-1:0]  pending,
  output logic [1:0]        fsm_state
);

  localparam int IDX_W = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;
  localparam int CNT_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   last_grant;
  logic [IRQ_N-1:0]   pending_q, pending_n, clr_mask;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               load;
  logic               arb_valid;
  logic [IDX_W-1:0]   arb_idx;

  taxi_pcie_irq_rr_arb #(
    .IRQ_N (IRQ_N),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (pending_q),
    .last  (last_grant),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  // Next-state logic; load marks an edge that issues the current arbiter winner.
  // The holdoff counter expiring is handled like IDLE in the same edge so the
  // gap between beats is exactly HOLDOFF_CYCLES idle cycles.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (enable && arb_valid) begin
          load    = 1'b1;
          state_n = VALID;
        end
      end
      VALID: begin
        if (m_axis_irq_tready) begin
          if (HOLDOFF_CYCLES > 0) begin
            state_n = HOLD;
            cnt_n   = CNT_W'(HOLDOFF_CYCLES);
          end else if (enable && arb_valid) begin
            load    = 1'b1;
            state_n = VALID;
          end else begin
            state_n = IDLE;
          end
        end
      end
      HOLD: begin
        if (cnt <= CNT_W'(1)) begin
          cnt_n = '0;
          if (enable && arb_valid) begin
            load    = 1'b1;
            state_n = VALID;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // A new request wins over the clear of the bit being issued in the same edge.
  always_comb begin
    clr_mask  = load ? (IRQ_N'(1) << arb_idx) : '0;
    pending_n = (pending_q & ~clr_mask) | irq_req;
  end

  // State, counter, pending vector and issued index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pending_q  <= '0;
      idx_q      <= '0;
      last_grant <= IDX_W'(IRQ_N - 1);
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pending_q <= pending_n;
      if (load) begin
        idx_q      <= arb_idx;
        last_grant <= arb_idx;
      end
    end
  end

  assign m_axis_irq_tvalid = (state == VALID);
  assign m_axis_irq_tdata  = DATA_W'(idx_q);
  assign m_axis_irq_tlast  = 1'b1;
  assign m_axis_irq_tkeep  = 1'b0;
  assign m_axis_irq_tid    = 1'b0;
  assign m_axis_irq_tdest  = 1'b0;
  assign m_axis_irq_tuser  = 1'b0;
  assign pending           = pending_q;
  assign fsm_state         = state;

endmodule

// File: tb/tb_taxi_pcie_irq_gen.sv
// Bench for taxi_pcie_irq_gen: one instance without holdoff, one with a
// four-cycle holdoff. Directed stimulus pushes expected indices into queues;
// negedge monitors pop and compare on every handshake.
module tb_taxi_pcie_irq_gen;

  localparam int N = 32;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0 (no holdoff)
  logic [N-1:0] irq0, pend0;
  logic         en0, rdy0, tv0, tl0;
  logic [4:0]   td0;
  logic [0:0]   tk0, ti0, tde0, tu0;
  logic [1:0]   st0;

  // Instance 1 (holdoff of 4)
  logic [N-1:0] irq1, pend1;
  logic         en1, rdy1, tv1, tl1;
  logic [4:0]   td1;
  logic [0:0]   tk1, ti1, tde1, tu1;
  logic [1:0]   st1;

  taxi_pcie_irq_gen #(.IRQ_N(N), .HOLDOFF_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .irq_req(irq0), .enable(en0),
    .m_axis_irq_tdata(td0), .m_axis_irq_tkeep(tk0), .m_axis_irq_tvalid(tv0),
    .m_axis_irq_tready(rdy0), .m_axis_irq_tlast(tl0), .m_axis_irq_tid(ti0),
    .m_axis_irq_tdest(tde0), .m_axis_irq_tuser(tu0), .pending(pend0), .fsm_state(st0)
  );

  taxi_pcie_irq_gen #(.IRQ_N(N), .HOLDOFF_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst), .irq_req(irq1), .enable(en1),
    .m_axis_irq_tdata(td1), .m_axis_irq_tkeep(tk1), .m_axis_irq_tvalid(tv1),
    .m_axis_irq_tready(rdy1), .m_axis_irq_tlast(tl1), .m_axis_irq_tid(ti1),
    .m_axis_irq_tdest(tde1), .m_axis_irq_tuser(tu1), .pending(pend1), .fsm_state(st1)
  );

  // Scoreboard
  logic [4:0] exp_q0[$];
  logic [4:0] exp_q1[$];
  int n_cmp = 0;
  int n_bad = 0;
  int gap_checked = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    irq0 = '0;
    irq1 = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // Monitor for instance 0: handshake beats and hold stability
  logic       hold0;
  logic [4:0] hold_d0;
  always @(negedge clk) begin
    if (rst) begin
      hold0 = 1'b0;
    end else begin
      if (hold0) begin
        check("stable_valid0", {31'd0, tv0}, 32'd1);
        check("stable_data0", {27'd0, td0}, {27'd0, hold_d0});
      end
      if (tv0 && rdy0) begin
        if (exp_q0.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat0: got index %0d expected no beat at %0t", td0, $time);
        end else begin
          check("beat0", {27'd0, td0}, {27'd0, exp_q0.pop_front()});
        end
        check("sideband0", {27'd0, tl0, tk0, ti0, tde0, tu0}, 32'h10);
      end
      hold0   = tv0 && !rdy0;
      hold_d0 = td0;
    end
  end

  // Monitor for instance 1: beats and the idle gap after each handshake
  logic arm1;
  int   zeros1;
  always @(negedge clk) begin
    if (rst) begin
      arm1   = 1'b0;
      zeros1 = 0;
    end else begin
      if (tv1) begin
        if (arm1) begin
          check("holdoff_gap", zeros1, 32'd4);
          gap_checked++;
          arm1 = 1'b0;
        end
      end else begin
        zeros1++;
      end
      if (tv1 && rdy1) begin
        if (exp_q1.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat1: got index %0d expected no beat at %0t", td1, $time);
        end else begin
          check("beat1", {27'd0, td1}, {27'd0, exp_q1.pop_front()});
        end
        arm1   = 1'b1;
        zeros1 = 0;
      end
    end
  end

  // Directed stimulus
  initial begin
    rst  = 1'b1;
    irq0 = '0;
    irq1 = '0;
    en0  = 1'b1;
    rdy0 = 1'b1;
    en1  = 1'b1;
    rdy1 = 1'b1;
    tick(2);
    check("rst_tvalid", {31'd0, tv0}, 32'd0);
    check("rst_tdata", {27'd0, td0}, 32'd0);
    check("rst_pending", pend0, 32'd0);
    check("rst_state", {30'd0, st0}, 32'd0);
    check("rst_tvalid1", {31'd0, tv1}, 32'd0);
    rst = 1'b0;
    tick(1);

    // Single pulse on vector 5: latency and a single beat
    exp_q0.push_back(5'd5);
    irq0 = 32'h1 << 5;
    tick(1);
    irq0 = '0;
    check("lat_pending", pend0, 32'h20);
    check("lat_tvalid_k", {31'd0, tv0}, 32'd0);
    tick(1);
    check("lat_tvalid_k1", {31'd0, tv0}, 32'd1);
    check("lat_tdata", {27'd0, td0}, 32'd5);
    tick(1);
    check("single_idle", {31'd0, tv0}, 32'd0);
    check("single_pending", pend0, 32'd0);

    // Three vectors at once, back-to-back beats, then round-robin wrap
    do_reset();
    exp_q0.push_back(5'd3);
    exp_q0.push_back(5'd7);
    exp_q0.push_back(5'd20);
    irq0 = (32'h1 << 3) | (32'h1 << 7) | (32'h1 << 20);
    tick(1);
    irq0 = '0;
    tick(1);
    check("rr_a0", {27'd0, td0}, 32'd3);
    tick(1);
    check("rr_a1", {27'd0, td0}, 32'd7);
    check("rr_a1_valid", {31'd0, tv0}, 32'd1);
    tick(1);
    check("rr_a2", {27'd0, td0}, 32'd20);
    tick(1);
    check("rr_a_idle", {31'd0, tv0}, 32'd0);

    exp_q0.push_back(5'd3);
    exp_q0.push_back(5'd7);
    irq0 = (32'h1 << 3) | (32'h1 << 7);
    tick(1);
    irq0 = '0;
    tick(1);
    check("rr_b0", {27'd0, td0}, 32'd3);
    tick(1);
    check("rr_b1", {27'd0, td0}, 32'd7);
    tick(1);

    // Last grant is 7, so 9 is searched before 2
    exp_q0.push_back(5'd9);
    exp_q0.push_back(5'd2);
    irq0 = (32'h1 << 2) | (32'h1 << 9);
    tick(1);
    irq0 = '0;
    tick(1);
    check("rr_c0", {27'd0, td0}, 32'd9);
    tick(1);
    check("rr_c1", {27'd0, td0}, 32'd2);
    tick(1);

    // Held request under backpressure coalesces into one extra beat
    rdy0 = 1'b0;
    exp_q0.push_back(5'd9);
    exp_q0.push_back(5'd9);
    irq0 = 32'h1 << 9;
    tick(10);
    irq0 = '0;
    check("coal_valid", {31'd0, tv0}, 32'd1);
    check("coal_data", {27'd0, td0}, 32'd9);
    check("coal_pending", pend0, 32'h200);
    rdy0 = 1'b1;
    tick(3);
    check("coal_idle", {31'd0, tv0}, 32'd0);
    check("coal_pending_clr", pend0, 32'd0);

    // Reset while a beat is waiting: everything dropped at once
    rdy0 = 1'b0;
    irq0 = (32'h1 << 4) | (32'h1 << 6);
    tick(1);
    irq0 = '0;
    tick(1);
    check("mid_valid", {31'd0, tv0}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_tvalid", {31'd0, tv0}, 32'd0);
    check("async_pending", pend0, 32'd0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    rdy0 = 1'b1;
    tick(5);
    check("post_rst_idle", {31'd0, tv0}, 32'd0);
    check("post_rst_pending", pend0, 32'd0);

    // Disabled: requests accumulate, nothing issued until enable returns
    en0  = 1'b0;
    irq0 = 32'h8000_0001;
    tick(1);
    irq0 = '0;
    tick(3);
    check("dis_tvalid", {31'd0, tv0}, 32'd0);
    check("dis_pending", pend0, 32'h8000_0001);
    exp_q0.push_back(5'd0);
    exp_q0.push_back(5'd31);
    en0 = 1'b1;
    tick(1);
    check("en_beat0", {27'd0, td0}, 32'd0);
    tick(1);
    check("en_beat1", {27'd0, td0}, 32'd31);
    tick(1);
    check("en_idle", {31'd0, tv0}, 32'd0);
    check("en_pending", pend0, 32'd0);

    // Holdoff instance: beat 1, four idle cycles, beat 2
    do_reset();
    exp_q1.push_back(5'd1);
    exp_q1.push_back(5'd2);
    irq1 = (32'h1 << 1) | (32'h1 << 2);
    tick(1);
    irq1 = '0;
    tick(1);
    check("ho_first", {27'd0, td1}, 32'd1);
    check("ho_first_valid", {31'd0, tv1}, 32'd1);
    tick(12);
    check("ho_idle", {31'd0, tv1}, 32'd0);
    check("ho_pending", pend1, 32'd0);

    check("q0_drained", exp_q0.size(), 32'd0);
    check("q1_drained", exp_q1.size(), 32'd0);
    check("gap_seen", gap_checked, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
